// File: rtl/ram2_ctrl.sv
// Burst master for the 32x32 single-port RAM: takes read/write bursts from a client,
// sequences RAM enables/addresses and owns the bidirectional data bus while writing.
module ram2_ctrl #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          ram_ena,
    output logic          ram_wena,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TURN = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e        state_q;
    logic [AW:0]   rem_q;      // beats not yet handed to the RAM
    logic [AW-1:0] cur_q;
    logic [AW-1:0] cur_d;
    logic [AW:0]   rem_d;
    logic          last_rd_q;
    logic          oe_q;
    logic [DW-1:0] wdata_q;
    logic          req_ready_q;
    logic          wr_ready_q;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
    logic          done_q;
    logic          ram_ena_q;
    logic          ram_wena_q;
    logic [AW-1:0] ram_addr_q;

    assign cur_d = cur_q + AW'(1);
    assign rem_d = rem_q - (AW+1)'(1);

    // Burst sequencer: all outputs and the bus drive enable are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= {(AW+1){1'b0}};
            cur_q       <= {AW{1'b0}};
            last_rd_q   <= 1'b0;
            oe_q        <= 1'b0;
            wdata_q     <= {DW{1'b0}};
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= {DW{1'b0}};
            done_q      <= 1'b0;
            ram_ena_q   <= 1'b0;
            ram_wena_q  <= 1'b0;
            ram_addr_q  <= {AW{1'b0}};
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ram_ena_q  <= 1'b0;
                    ram_wena_q <= 1'b0;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        rem_q       <= {1'b0, req_len} + (AW+1)'(1);
                        if (req_we) begin
                            cur_q     <= req_addr;
                            last_rd_q <= 1'b0;
                            if (last_rd_q) begin
                                state_q <= S_TURN;
                            end else begin
                                state_q    <= S_WR;
                                wr_ready_q <= 1'b1;
                                oe_q       <= 1'b1;
                            end
                        end else begin
                            ram_ena_q  <= 1'b1;
                            ram_addr_q <= req_addr;
                            cur_q      <= req_addr + AW'(1);
                            state_q    <= S_RD;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_TURN: begin
                    state_q    <= S_WR;
                    wr_ready_q <= 1'b1;
                    oe_q       <= 1'b1;
                end
                S_WR: begin
                    if (wr_valid && wr_ready_q) begin
                        ram_ena_q  <= 1'b1;
                        ram_wena_q <= 1'b1;
                        ram_addr_q <= cur_q;
                        wdata_q    <= wr_data;
                        cur_q      <= cur_d;
                        rem_q      <= rem_d;
                        wr_ready_q <= (rem_q != (AW+1)'(1));
                    end else if (rem_q == {(AW+1){1'b0}}) begin
                        ram_ena_q  <= 1'b0;
                        ram_wena_q <= 1'b0;
                        oe_q       <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        ram_ena_q  <= 1'b0;
                        ram_wena_q <= 1'b0;
                    end
                end
                S_RD: begin
                    rd_data_q  <= ram_data;
                    rd_valid_q <= 1'b1;
                    rem_q      <= rem_d;
                    if (rem_q == (AW+1)'(1)) begin
                        ram_ena_q   <= 1'b0;
                        done_q      <= 1'b1;
                        req_ready_q <= 1'b1;
                        last_rd_q   <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        ram_addr_q <= cur_q;
                        cur_q      <= cur_d;
                    end
                end
                S_DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    oe_q        <= 1'b0;
                    wr_ready_q  <= 1'b0;
                    req_ready_q <= 1'b1;
                    ram_ena_q   <= 1'b0;
                    ram_wena_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign ram_ena   = ram_ena_q;
    assign ram_wena  = ram_wena_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = oe_q ? wdata_q : {DW{1'bz}};

endmodule
